multi_register_bank: RTL and testbench
======================================

# multi_register_bank

Parametrised bank of NRegs clocked general-purpose registers, each supporting the clear/load/decrement/increment function set plus hold and half-word loads. One shared function select acts on all registers enabled by a one-hot mask, and two independent combinational read ports are provided. Per-register wrap flags report increment/decrement overflow. The bank sits in the datapath as the general/address register file feeding the ALU and memory address muxes.

## Interface
- NBits, 16, register width; must be even and at least 2
- NRegs, 4, number of registers; at least 2
- SelW, derived as $clog2(NRegs), width of read selects

- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- funsel  in  3  function applied to every enabled register
- regsel  in  NRegs  enable mask; bit k enables register k; any number of bits may be set
- i  in  NBits  load data
- outasel  in  SelW  read port A select
- outbsel  in  SelW  read port B select
- outa  out  NBits  contents of register outasel
- outb  out  NBits  contents of register outbsel
- wrap  out  NRegs  registered per-register wrap flags

## Operation
- funsel codes apply to each register k whose regsel[k] = 1. Registers with regsel[k] = 0 hold.
  - 000: hold
  - 001: clear to 0
  - 010: load i
  - 011: decrement by 1, modulo 2^NBits
  - 100: increment by 1, modulo 2^NBits
  - 101: load low half. Bits [NBits/2-1:0] take i[NBits/2-1:0]; the upper half holds.
  - 110: load high half. Bits [NBits-1:NBits/2] take i[NBits/2-1:0]; the lower half holds.
  - 111: reserved; behaves as hold.
- Every enabled register performs the same operation in the same cycle. No priority exists between registers.
- Arithmetic is unsigned, NBits wide, and wraps: 0 - 1 = all-ones, and all-ones + 1 = 0.
- wrap[k] update rules:
  - Set for one cycle after register k increments from all-ones.
  - Set for one cycle after register k decrements from 0.
  - Otherwise cleared on every clock edge, including when register k is not enabled.
- Read ports are combinational muxes of the current register state.
  - There is no write-through bypass: a read in the same cycle as a write returns the pre-edge value.
  - outasel and outbsel may be equal; both ports then show the same register.
  - Select values ≥ NRegs (non-power-of-2 NRegs) drive all zeros on that port.
- Reset:
  - rst_n low immediately forces all registers to 0 and wrap to 0, independent of clk.
  - outa and outb therefore read 0 during reset.
  - Reset asserted mid-sequence discards any in-progress operation.
  - The first edge after rst_n rises performs the operation then presented.

## Timing
- Write latency: 1 clock. The new value is visible on outa/outb right after the rising edge following setup of funsel, regsel and i.
- Read latency: 0 (combinational from the state and select inputs).
- wrap is valid in the cycle after the wrapping edge and lasts exactly 1 cycle unless the wrap repeats.
- Back-to-back operations on the same register are allowed every cycle; each edge applies exactly one operation.
- No handshake: the caller holds inputs stable around the clock edge.
- Reset values: all registers 0, outa 0, outb 0, wrap all 0.

## Test plan
- Reset with registers preloaded 16'hABCD, rst_n pulsed low between edges -> outa, outb and wrap read 0 immediately, before the next clk.
- regsel=4'b0101, funsel=010, i=16'h1234; one edge -> R0=R2=16'h1234, R1=R3 unchanged. Then outasel=0, outbsel=2 -> both ports read 16'h1234.
- R1=16'hFFFF, funsel=100, regsel=4'b0010 -> R1=0 and wrap=4'b0010 for one cycle. Next edge with funsel=000 -> wrap=0.
- R3=0, funsel=011 -> R3=16'hFFFF, wrap[3]=1. A second decrement -> 16'hFFFE, wrap[3]=0.
- R0=16'h0000, funsel=101, i=16'h00AB -> R0=16'h00AB. Then funsel=110, i=16'h00CD -> R0=16'hCDAB.
- Same-cycle read: R2=5, funsel=100 with outasel=2 -> outa=5 before the edge, 6 after. funsel=111 on all registers -> no change.

Source files
------------

// File: rtl/multi_register_bank.sv
// Bank of NRegs general/address registers sharing one function select over a one-hot-style
// enable mask, with two combinational read ports and registered per-register wrap flags.
module multi_register_bank #(
    parameter  int NBits = 16,
    parameter  int NRegs = 4,
    localparam int SelW  = $clog2(NRegs)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       funsel,
    input  logic [NRegs-1:0] regsel,
    input  logic [NBits-1:0] i,
    input  logic [SelW-1:0]  outasel,
    input  logic [SelW-1:0]  outbsel,
    output logic [NBits-1:0] outa,
    output logic [NBits-1:0] outb,
    output logic [NRegs-1:0] wrap
);

    typedef enum logic [2:0] {
        FN_HOLD    = 3'b000,
        FN_CLEAR   = 3'b001,
        FN_LOAD    = 3'b010,
        FN_DEC     = 3'b011,
        FN_INC     = 3'b100,
        FN_LOAD_LO = 3'b101,
        FN_LOAD_HI = 3'b110,
        FN_RSVD    = 3'b111
    } fun_t;

    localparam int               Half     = NBits / 2;
    localparam logic [NBits-1:0] One      = NBits'(1);
    localparam logic [SelW:0]    NRegsCmp = (SelW + 1)'(NRegs);

    logic [NBits-1:0] regs      [NRegs];
    logic [NBits-1:0] regs_next [NRegs];
    logic [NRegs-1:0] wrap_next;
    fun_t             fun;

    assign fun = fun_t'(funsel);

    // Every register computes its candidate next value from the shared function;
    // disabled registers simply recirculate their current contents.
    always_comb begin
        // NOTE: each output gets a default before any branch so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        wrap_next = '0;
        for (int k = 0; k < NRegs; k++) begin
            regs_next[k] = regs[k];
            if (regsel[k]) begin
                unique case (fun)
                    FN_CLEAR:   regs_next[k] = '0;
                    FN_LOAD:    regs_next[k] = i;
                    FN_DEC: begin
                        regs_next[k] = regs[k] - One;
                        wrap_next[k] = (regs[k] == '0);
                    end
                    FN_INC: begin
                        regs_next[k] = regs[k] + One;
                        wrap_next[k] = (regs[k] == '1);
                    end
                    FN_LOAD_LO: regs_next[k] = {regs[k][NBits-1:Half], i[Half-1:0]};
                    FN_LOAD_HI: regs_next[k] = {i[Half-1:0], regs[k][Half-1:0]};
                    FN_HOLD, FN_RSVD: regs_next[k] = regs[k];
                endcase
            end
        end
    end

    // NOTE: the bank is a handful of flops feeding the datapath, not a RAM macro,
    // so every entry is cleared by reset rather than left uninitialised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NRegs; k++) begin
                regs[k] <= '0;
            end
            wrap <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers
            // update together from pre-edge values.
            for (int k = 0; k < NRegs; k++) begin
                regs[k] <= regs_next[k];
            end
            wrap <= wrap_next;
        end
    end

    // Selects beyond the last register (non-power-of-2 NRegs) read as zero.
    always_comb begin
        outa = '0;
        outb = '0;
        if ({1'b0, outasel} < NRegsCmp) begin
            outa = regs[outasel];
        end
        if ({1'b0, outbsel} < NRegsCmp) begin
            outb = regs[outbsel];
        end
    end

endmodule

// File: tb/tb_multi_register_bank.sv
// Directed bench for multi_register_bank: one task per feature, each with inline
// comparisons against hand-computed values.
module tb_multi_register_bank;

    localparam int NBits = 16;
    localparam int NRegs = 4;
    localparam int SelW  = 2;

    localparam logic [2:0] F_HOLD  = 3'b000;
    localparam logic [2:0] F_CLEAR = 3'b001;
    localparam logic [2:0] F_LOAD  = 3'b010;
    localparam logic [2:0] F_DEC   = 3'b011;
    localparam logic [2:0] F_INC   = 3'b100;
    localparam logic [2:0] F_LO    = 3'b101;
    localparam logic [2:0] F_HI    = 3'b110;
    localparam logic [2:0] F_RSVD  = 3'b111;

    logic             clk;
    logic             rst_n;
    logic [2:0]       funsel;
    logic [NRegs-1:0] regsel;
    logic [NBits-1:0] i;
    logic [SelW-1:0]  outasel;
    logic [SelW-1:0]  outbsel;
    logic [NBits-1:0] outa;
    logic [NBits-1:0] outb;
    logic [NRegs-1:0] wrap;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    multi_register_bank #(.NBits(NBits), .NRegs(NRegs)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .funsel  (funsel),
        .regsel  (regsel),
        .i       (i),
        .outasel (outasel),
        .outbsel (outbsel),
        .outa    (outa),
        .outb    (outb),
        .wrap    (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operation for exactly one rising edge, then return to hold.
    task automatic do_op(input logic [2:0] f, input logic [NRegs-1:0] m, input logic [NBits-1:0] d);
        @(negedge clk);
        funsel = f;
        regsel = m;
        i      = d;
        @(posedge clk);
        #1;
        funsel = F_HOLD;
        regsel = '0;
    endtask

    task automatic sel(input int a, input int b);
        outasel = SelW'(a);
        outbsel = SelW'(b);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; funsel = F_HOLD; regsel = '0; i = '0; outasel = '0; outbsel = 2'd3;
        #2;
        n_tests++; if (outa !== 16'h0) begin n_fail++; $display("FAIL reset_outa got %h want 0000", outa); end
        n_tests++; if (outb !== 16'h0) begin n_fail++; $display("FAIL reset_outb got %h want 0000", outb); end
        n_tests++; if (wrap !== 4'b0)  begin n_fail++; $display("FAIL reset_wrap got %b want 0000", wrap); end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(F_LOAD, 4'b1110, 16'hABCD);
        do_op(F_LOAD, 4'b0001, 16'hFFFF);
        do_op(F_INC,  4'b0001, 16'h0);
        sel(1, 3);
        n_tests++; if (outa !== 16'hABCD) begin n_fail++; $display("FAIL preload_outa got %h want abcd", outa); end
        n_tests++; if (wrap !== 4'b0001)  begin n_fail++; $display("FAIL preload_wrap got %b want 0001", wrap); end
        // Asynchronous reset between edges: outputs clear before the next clk edge.
        rst_n = 1'b0;
        #1;
        n_tests++; if (outa !== 16'h0) begin n_fail++; $display("FAIL async_reset_outa got %h want 0000", outa); end
        n_tests++; if (outb !== 16'h0) begin n_fail++; $display("FAIL async_reset_outb got %h want 0000", outb); end
        n_tests++; if (wrap !== 4'b0)  begin n_fail++; $display("FAIL async_reset_wrap got %b want 0000", wrap); end
        rst_n = 1'b1;
        // The first edge after release performs the operation then presented.
        do_op(F_LOAD, 4'b0001, 16'h0042);
        sel(0, 1);
        n_tests++; if (outa !== 16'h0042) begin n_fail++; $display("FAIL first_edge_op got %h want 0042", outa); end
        n_tests++; if (outb !== 16'h0000) begin n_fail++; $display("FAIL first_edge_other got %h want 0000", outb); end
    endtask

    task automatic test_load_mask();
        do_op(F_LOAD, 4'b1010, 16'h5555);
        do_op(F_LOAD, 4'b0101, 16'h1234);
        sel(0, 2);
        n_tests++; if (outa !== 16'h1234) begin n_fail++; $display("FAIL load_r0 got %h want 1234", outa); end
        n_tests++; if (outb !== 16'h1234) begin n_fail++; $display("FAIL load_r2 got %h want 1234", outb); end
        sel(1, 3);
        n_tests++; if (outa !== 16'h5555) begin n_fail++; $display("FAIL load_r1_held got %h want 5555", outa); end
        n_tests++; if (outb !== 16'h5555) begin n_fail++; $display("FAIL load_r3_held got %h want 5555", outb); end
        sel(2, 2);
        n_tests++; if (outa !== outb || outa !== 16'h1234) begin n_fail++; $display("FAIL same_select got a=%h b=%h want 1234", outa, outb); end
        do_op(F_CLEAR, 4'b0100, 16'hFFFF);
        sel(2, 0);
        n_tests++; if (outa !== 16'h0000) begin n_fail++; $display("FAIL clear_r2 got %h want 0000", outa); end
        n_tests++; if (outb !== 16'h1234) begin n_fail++; $display("FAIL clear_r0_held got %h want 1234", outb); end
    endtask

    task automatic test_inc_wrap();
        do_op(F_LOAD, 4'b0010, 16'hFFFF);
        do_op(F_INC,  4'b0010, 16'h0);
        sel(1, 0);
        n_tests++; if (outa !== 16'h0000) begin n_fail++; $display("FAIL inc_wrap_value got %h want 0000", outa); end
        n_tests++; if (wrap !== 4'b0010)  begin n_fail++; $display("FAIL inc_wrap_flag got %b want 0010", wrap); end
        n_tests++; if (outb !== 16'h1234) begin n_fail++; $display("FAIL inc_r0_held got %h want 1234", outb); end
        do_op(F_HOLD, 4'b0000, 16'h0);
        n_tests++; if (wrap !== 4'b0000)  begin n_fail++; $display("FAIL inc_wrap_clear got %b want 0000", wrap); end
    endtask

    task automatic test_dec_wrap();
        do_op(F_CLEAR, 4'b1000, 16'h0);
        do_op(F_DEC,   4'b1000, 16'h0);
        sel(3, 1);
        n_tests++; if (outa !== 16'hFFFF) begin n_fail++; $display("FAIL dec_wrap_value got %h want ffff", outa); end
        n_tests++; if (wrap !== 4'b1000)  begin n_fail++; $display("FAIL dec_wrap_flag got %b want 1000", wrap); end
        do_op(F_DEC, 4'b1000, 16'h0);
        n_tests++; if (outa !== 16'hFFFE) begin n_fail++; $display("FAIL dec_second got %h want fffe", outa); end
        n_tests++; if (wrap !== 4'b0000)  begin n_fail++; $display("FAIL dec_second_flag got %b want 0000", wrap); end
    endtask

    task automatic test_half_load();
        do_op(F_CLEAR, 4'b0001, 16'h0);
        do_op(F_LO,    4'b0001, 16'h00AB);
        sel(0, 1);
        n_tests++; if (outa !== 16'h00AB) begin n_fail++; $display("FAIL load_lo got %h want 00ab", outa); end
        do_op(F_HI, 4'b0001, 16'h00CD);
        n_tests++; if (outa !== 16'hCDAB) begin n_fail++; $display("FAIL load_hi got %h want cdab", outa); end
        // Only the low half of i is used by either half-load.
        do_op(F_LO, 4'b0001, 16'hFF12);
        n_tests++; if (outa !== 16'hCD12) begin n_fail++; $display("FAIL load_lo_upper_i got %h want cd12", outa); end
    endtask

    task automatic test_same_cycle_read();
        do_op(F_LOAD, 4'b0100, 16'h0005);
        @(negedge clk);
        funsel = F_INC; regsel = 4'b0100; outasel = 2'd2;
        #1;
        n_tests++; if (outa !== 16'h0005) begin n_fail++; $display("FAIL pre_edge_read got %h want 0005", outa); end
        @(posedge clk);
        #1;
        funsel = F_HOLD; regsel = '0;
        n_tests++; if (outa !== 16'h0006) begin n_fail++; $display("FAIL post_edge_read got %h want 0006", outa); end
    endtask

    task automatic test_reserved();
        do_op(F_RSVD, 4'b1111, 16'h9999);
        sel(0, 1);
        n_tests++; if (outa !== 16'hCD12) begin n_fail++; $display("FAIL rsvd_r0 got %h want cd12", outa); end
        n_tests++; if (outb !== 16'h0000) begin n_fail++; $display("FAIL rsvd_r1 got %h want 0000", outb); end
        sel(2, 3);
        n_tests++; if (outa !== 16'h0006) begin n_fail++; $display("FAIL rsvd_r2 got %h want 0006", outa); end
        n_tests++; if (outb !== 16'hFFFE) begin n_fail++; $display("FAIL rsvd_r3 got %h want fffe", outb); end
        n_tests++; if (wrap !== 4'b0000)  begin n_fail++; $display("FAIL rsvd_wrap got %b want 0000", wrap); end
    endtask

    task automatic test_back_to_back();
        // All four registers increment together; only R3 crosses all-ones.
        do_op(F_LOAD, 4'b1000, 16'hFFFF);
        do_op(F_INC,  4'b1111, 16'h0);
        sel(0, 3);
        n_tests++; if (outa !== 16'hCD13) begin n_fail++; $display("FAIL multi_inc_r0 got %h want cd13", outa); end
        n_tests++; if (outb !== 16'h0000) begin n_fail++; $display("FAIL multi_inc_r3 got %h want 0000", outb); end
        n_tests++; if (wrap !== 4'b1000)  begin n_fail++; $display("FAIL multi_inc_wrap got %b want 1000", wrap); end
        // Consecutive-edge operations on one register without idle cycles.
        @(negedge clk);
        funsel = F_DEC; regsel = 4'b0010; outasel = 2'd1;
        @(posedge clk); #1;
        n_tests++; if (outa !== 16'h0000) begin n_fail++; $display("FAIL b2b_dec1 got %h want 0000", outa); end
        n_tests++; if (wrap !== 4'b0000)  begin n_fail++; $display("FAIL b2b_dec1_wrap got %b want 0000", wrap); end
        @(posedge clk); #1;
        n_tests++; if (outa !== 16'hFFFF) begin n_fail++; $display("FAIL b2b_dec2 got %h want ffff", outa); end
        n_tests++; if (wrap !== 4'b0010)  begin n_fail++; $display("FAIL b2b_dec2_wrap got %b want 0010", wrap); end
        @(negedge clk);
        funsel = F_INC;
        @(posedge clk); #1;
        n_tests++; if (outa !== 16'h0000) begin n_fail++; $display("FAIL b2b_inc got %h want 0000", outa); end
        n_tests++; if (wrap !== 4'b0010)  begin n_fail++; $display("FAIL b2b_repeat_wrap got %b want 0010", wrap); end
        funsel = F_HOLD; regsel = '0;
        @(posedge clk); #1;
        n_tests++; if (wrap !== 4'b0000)  begin n_fail++; $display("FAIL b2b_wrap_clear got %b want 0000", wrap); end
    endtask

    initial begin
        test_reset();
        test_load_mask();
        test_inc_wrap();
        test_dec_wrap();
        test_half_load();
        test_same_cycle_read();
        test_reserved();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout after %0d tests", n_tests);
        $fatal(1);
    end

endmodule
